// File: rtl/elevator_pkg.sv
// Shared encodings for the SCAN elevator controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_call_reg.sv
// Latched call bitmap (clear beats set on the same edge) plus the
// above/below/here reductions against the cab position.
module elevator_call_reg #(
  parameter int NUM_FLOORS = 10,
  parameter int FLOOR_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [FLOOR_W-1:0]    set_floor,
  input  logic                  clr_en,
  input  logic [FLOOR_W-1:0]    clr_floor,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic [FLOOR_W-1:0]    query_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  above,
  output logic                  below,
  output logic                  here,
  output logic                  query_hit
);

  logic [NUM_FLOORS-1:0] pending_d;

  // Out-of-range floors match no bit, so they fall through untouched.
  always_comb begin
    pending_d = pending;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (set_en && set_floor == FLOOR_W'(i)) pending_d[i] = 1'b1;
      if (clr_en && clr_floor == FLOOR_W'(i)) pending_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_d;
  end

  always_comb begin
    above     = 1'b0;
    below     = 1'b0;
    here      = 1'b0;
    query_hit = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i]) begin
        if (FLOOR_W'(i) > current_floor)  above     = 1'b1;
        if (FLOOR_W'(i) < current_floor)  below     = 1'b1;
        if (FLOOR_W'(i) == current_floor) here      = 1'b1;
        if (FLOOR_W'(i) == query_floor)   query_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator controller: travel/door timing and direction scheduling
// on top of the latched call bitmap.
//   state     | meaning
//   IDLE      | parked, no call being served
//   MOVE_UP   | travelling toward higher floors
//   MOVE_DOWN | travelling toward lower floors
//   DOOR_OPEN | stopped at a served floor, dwell running
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 10,
  parameter int FLOOR_W       = 4,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [1:0]            state,
  output logic                  dir_up,
  output logic                  door_open,
  output logic                  arrive
);

  localparam int TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DOOR_W   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [TRAVEL_W-1:0] TRAVEL_ONE  = TRAVEL_W'(1);
  localparam logic [DOOR_W-1:0]   DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [DOOR_W-1:0]   DOOR_ONE    = DOOR_W'(1);
  localparam logic [FLOOR_W-1:0]  TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0]  ONE_FLOOR   = FLOOR_W'(1);

  state_t                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_d, query_floor, clr_floor;
  logic                  dir_d, arrive_d;
  logic [TRAVEL_W-1:0]   travel_cnt, travel_cnt_d;
  logic [DOOR_W-1:0]     door_cnt, door_cnt_d;
  logic                  set_en, clr_en, hold_door;
  logic                  above, below, here, query_hit;

  // A call for the floor we are standing at with the door open just extends the dwell.
  assign hold_door   = call_valid && (state_q == DOOR_OPEN) && (call_floor == current_floor);
  assign set_en      = call_valid && !hold_door;
  assign query_floor = (state_q == MOVE_DOWN) ? current_floor - ONE_FLOOR
                                              : current_floor + ONE_FLOOR;

  elevator_call_reg #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_call_reg (
    .clk           (clk),
    .reset         (reset),
    .set_en        (set_en),
    .set_floor     (call_floor),
    .clr_en        (clr_en),
    .clr_floor     (clr_floor),
    .current_floor (current_floor),
    .query_floor   (query_floor),
    .pending       (pending),
    .above         (above),
    .below         (below),
    .here          (here),
    .query_hit     (query_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      current_floor <= '0;
      dir_up        <= DIR_UP;
      arrive        <= 1'b0;
      travel_cnt    <= '0;
      door_cnt      <= '0;
    end else begin
      state_q       <= state_d;
      current_floor <= floor_d;
      dir_up        <= dir_d;
      arrive        <= arrive_d;
      travel_cnt    <= travel_cnt_d;
      door_cnt      <= door_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    floor_d      = current_floor;
    dir_d        = dir_up;
    arrive_d     = 1'b0;
    travel_cnt_d = '0;
    door_cnt_d   = '0;
    clr_en       = 1'b0;
    clr_floor    = query_floor;
    case (state_q)
      IDLE: begin
        if (here) begin
          state_d   = DOOR_OPEN;
          clr_en    = 1'b1;
          clr_floor = current_floor;
          arrive_d  = 1'b1;
        end else if (above && (dir_up || !below)) begin
          state_d = MOVE_UP;
          dir_d   = DIR_UP;
        end else if (below) begin
          state_d = MOVE_DOWN;
          dir_d   = DIR_DOWN;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        travel_cnt_d = travel_cnt + TRAVEL_ONE;
        if (travel_cnt == TRAVEL_LAST) begin
          travel_cnt_d = '0;
          // Unreachable with consistent pending state; park rather than wrap.
          if ((state_q == MOVE_UP && current_floor == TOP_FLOOR) ||
              (state_q == MOVE_DOWN && current_floor == '0)) begin
            state_d = IDLE;
          end else begin
            floor_d = query_floor;
            if (query_hit) begin
              state_d  = DOOR_OPEN;
              clr_en   = 1'b1;
              arrive_d = 1'b1;
            end
          end
        end
      end
      DOOR_OPEN: begin
        door_cnt_d = door_cnt + DOOR_ONE;
        if (hold_door) begin
          door_cnt_d = '0;
        end else if (door_cnt == DOOR_LAST) begin
          door_cnt_d = '0;
          if (dir_up && above) begin
            state_d = MOVE_UP;
          end else if (!dir_up && below) begin
            state_d = MOVE_DOWN;
          end else if (dir_up && below) begin
            state_d = MOVE_DOWN;
            dir_d   = DIR_DOWN;
          end else if (!dir_up && above) begin
            state_d = MOVE_UP;
            dir_d   = DIR_UP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    state     = state_q;
    door_open = (state_q == DOOR_OPEN);
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scenario bench for elevator_scan_ctrl; expected stops are queued when
// calls are driven and matched against each arrive pulse.
module tb_elevator_scan_ctrl;
  import elevator_pkg::*;

  localparam int NF = 10;
  localparam int FW = 4;
  localparam int TC = 4;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          call_valid = 1'b0;
  logic [FW-1:0] call_floor = '0;
  logic [NF-1:0] pending;
  logic [FW-1:0] current_floor;
  logic [1:0]    state;
  logic          dir_up, door_open, arrive;

  int cyc;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int flr;
    int at;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  elevator_scan_ctrl #(
    .NUM_FLOORS    (NF),
    .FLOOR_W       (FW),
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .call_valid    (call_valid),
    .call_floor    (call_floor),
    .pending       (pending),
    .current_floor (current_floor),
    .state         (state),
    .dir_up        (dir_up),
    .door_open     (door_open),
    .arrive        (arrive)
  );

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Caller is at a negedge; the call is sampled on the next posedge.
  task automatic do_call(input int f);
    call_valid = 1'b1;
    call_floor = f[FW-1:0];
    @(negedge clk);
    call_valid = 1'b0;
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, state, IDLE);
    check({tag, "_floor"}, current_floor, 0);
    check({tag, "_pending"}, pending, 0);
    check({tag, "_dir"}, dir_up, 1);
    check({tag, "_door"}, door_open, 0);
    check({tag, "_arrive"}, arrive, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && arrive) begin
      if (sb_q.size() == 0) begin
        check("arrive_unexpected", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("arrive_floor", current_floor, e.flr);
        check("arrive_edge", cyc, e.at);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // single call up from floor 0
    e = cyc + 1;
    sb_q.push_back('{3, e + 1 + 3*TC});
    do_call(3);
    check("s1_pending", pending, 10'b00_0000_1000);
    check("s1_still_idle", state, IDLE);
    @(negedge clk);
    check("s1_move", state, MOVE_UP);
    wait_edge(e + 1 + TC);   check("s1_f1", current_floor, 1);
    wait_edge(e + 1 + 2*TC); check("s1_f2", current_floor, 2);
    wait_edge(e + 1 + 3*TC);
    check("s1_f3", current_floor, 3);
    check("s1_door_state", state, DOOR_OPEN);
    check("s1_door_open", door_open, 1);
    check("s1_cleared", pending, 0);
    wait_edge(e + 3*TC + DC); check("s1_door_last", door_open, 1);
    wait_edge(e + 1 + 3*TC + DC);
    check("s1_idle", state, IDLE);
    check("s1_door_closed", door_open, 0);

    // move to floor 5, keeping dir_up=1
    e = cyc + 1;
    sb_q.push_back('{5, e + 1 + 2*TC});
    do_call(5);
    wait_edge(e + 1 + 2*TC + DC);
    check("s2_pre_idle", state, IDLE);
    check("s2_pre_dir", dir_up, 1);

    // SCAN order: 8 then 2
    e = cyc + 1;
    sb_q.push_back('{8, e + 1 + 3*TC});
    sb_q.push_back('{2, e + 1 + 9*TC + DC});
    do_call(8);
    do_call(2);
    wait_edge(e + 1 + 3*TC + DC);
    check("s2_reverse_state", state, MOVE_DOWN);
    check("s2_reverse_dir", dir_up, 0);
    wait_edge(e + 1 + 9*TC + 2*DC);
    check("s2_idle", state, IDLE);
    check("s2_floor", current_floor, 2);
    check("s2_dir_end", dir_up, 0);
    check("s2_pending", pending, 0);

    // bad floor ignored, call at current floor, dwell restart
    e = cyc + 1;
    do_call(12);
    check("b_bad_pending", pending, 0);
    @(negedge clk);
    check("b_bad_state", state, IDLE);
    e = cyc + 1;
    sb_q.push_back('{2, e + 1});
    do_call(2);
    check("b_here_pending", pending, 10'b00_0000_0100);
    @(negedge clk);
    check("b_here_door", state, DOOR_OPEN);
    do_call(2);
    wait_edge(e + 4);
    check("b_dwell_ext", state, DOOR_OPEN);
    wait_edge(e + 5);
    check("b_dwell_end", state, IDLE);
    check("b_repeat_not_latched", pending, 0);

    // reset between floors while moving down
    e = cyc + 1;
    sb_q.push_back('{0, e + 1 + 2*TC});
    do_call(0);
    wait_edge(e + 6);
    check("r_moving", state, MOVE_DOWN);
    check("r_floor", current_floor, 1);
    reset = 1'b1;
    #1;
    check_reset_vals("r_async");
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // pickup en route 0 -> 7 with floor 4 injected
    e = cyc + 1;
    do_call(7);
    wait_edge(e + 1 + TC);
    check("p_floor1", current_floor, 1);
    sb_q.push_back('{4, e + 1 + 4*TC});
    sb_q.push_back('{7, e + 1 + 7*TC + DC});
    do_call(4);
    wait_edge(e + 1 + 4*TC);
    check("p_stop4", state, DOOR_OPEN);
    wait_edge(e + 1 + 4*TC + DC);
    check("p_resume", state, MOVE_UP);
    wait_edge(e + 1 + 7*TC + 2*DC);
    check("p_idle", state, IDLE);
    check("p_floor7", current_floor, 7);

    // call for 6 on the arrival edge at 6
    e = cyc + 1;
    sb_q.push_back('{6, e + 1 + TC});
    do_call(6);
    wait_edge(e + TC);
    do_call(6);
    check("c_cleared", pending, 0);
    check("c_door", state, DOOR_OPEN);
    wait_edge(e + 1 + TC + DC);
    check("c_idle", state, IDLE);
    repeat (10) @(negedge clk);
    check("c_stay_idle", state, IDLE);
    check("c_pending_end", pending, 0);
    check("c_floor", current_floor, 6);

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
